dig_capture: RTL and testbench

Measurement back-end fed by the free-running 8-bit `dig` counter. It drives the analog `discharge` switch, then waits for the comparator to trip. It timestamps the trip as elapsed counter ticks, using wrap-safe subtraction, and buffers results in a small FIFO read out with a valid/ready handshake. It sits between the counter/analog front-end and the readout logic.

---
 rtl/dig_pkg.sv | 20 ++
 rtl/dig_capture_if.sv | 26 ++
 rtl/dig_fifo.sv | 50 +++++
 rtl/dig_capture.sv | 152 +++++++++++++++
 tb/tb_dig_capture.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dig_pkg.sv
// Shared types and defaults for the dig capture back-end.
package dig_pkg;

    // Default counter / result width.
    localparam int DIG_WIDTH = 8;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        WAIT_CMP,
        DISCHARGE
    } cap_state_t;

    // One buffered measurement: timeout flag above the elapsed tick count.
    typedef struct packed {
        logic                 timeout;
        logic [DIG_WIDTH-1:0] elapsed;
    } cap_result_t;

endpackage

// File: rtl/dig_capture_if.sv
// Result readout channel: {timeout, elapsed} with a valid/ready handshake.
interface dig_capture_if
    import dig_pkg::*;
#(
    parameter int WIDTH = DIG_WIDTH
) ();

    logic [WIDTH:0] out_data;
    logic           out_valid;
    logic           out_ready;

    // Producer side (the capture block).
    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    // Consumer side (the readout logic).
    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/dig_fifo.sv
// Small synchronous result FIFO. A push into a full FIFO is accepted only
// when a pop happens on the same edge; otherwise the push is ignored.
module dig_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; reset clears contents so the head reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dig_capture.sv
// Measurement back-end: drives the discharge switch, timestamps the
// comparator trip against the free-running counter and buffers results.
module dig_capture
    import dig_pkg::*;
#(
    parameter int WIDTH      = DIG_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int DIS_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic             cmp,
    input  logic             clear,
    output logic             discharge,
    dig_capture_if.master    rd,
    output logic             overrun
);

    localparam int CW = $clog2(DIS_CYCLES + 1);

    cap_state_t     state;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] elapsed;
    logic [CW-1:0]  dis_cnt;

    logic           sync1;
    logic           sync2;
    logic           sync2_d;
    logic           cmp_rise;

    logic           push;
    logic [WIDTH:0] push_data;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic           drop;
    logic [WIDTH:0] fifo_dout;

    // Two-flop synchronizer for the asynchronous comparator plus edge-detect delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= cmp;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign cmp_rise = sync2 & ~sync2_d;

    // Wrap-safe elapsed ticks and the capture decision; a trip beats a timeout.
    always_comb begin
        elapsed   = count - start;
        push      = 1'b0;
        push_data = '0;
        if (state == WAIT_CMP && enable) begin
            if (cmp_rise) begin
                push      = 1'b1;
                push_data = {1'b0, elapsed};
            end else if (elapsed == '1) begin
                push      = 1'b1;
                push_data = {1'b1, elapsed};
            end
        end
    end

    // Sequencer with registered discharge output and pulse-length counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            start     <= '0;
            dis_cnt   <= '0;
            discharge <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    discharge <= 1'b1;
                    if (enable) begin
                        state     <= WAIT_CMP;
                        start     <= count;
                        discharge <= 1'b0;
                    end
                end
                WAIT_CMP: begin
                    if (!enable) begin
                        state     <= IDLE;
                        discharge <= 1'b1;
                    end else if (push) begin
                        state     <= DISCHARGE;
                        discharge <= 1'b1;
                        dis_cnt   <= CW'(DIS_CYCLES - 1);
                    end
                end
                DISCHARGE: begin
                    if (dis_cnt == '0) begin
                        if (enable) begin
                            state     <= WAIT_CMP;
                            start     <= count;
                            discharge <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            discharge <= 1'b1;
                        end
                    end else begin
                        dis_cnt <= dis_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    discharge <= 1'b1;
                end
            endcase
        end
    end

    assign pop  = rd.out_valid & rd.out_ready;
    assign drop = push & fifo_full & ~pop;

    // Sticky overrun flag; a new drop outranks a clear on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear) begin
            overrun <= 1'b0;
        end
    end

    dig_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (push_data),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd.out_data  = fifo_dout;
    assign rd.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_dig_capture.sv
// Directed scoreboard bench for dig_capture.
module tb_dig_capture;
    import dig_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int DIS   = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [W-1:0] count;
    logic         cmp;
    logic         clear;
    logic         discharge;
    logic         overrun;

    dig_capture_if #(.WIDTH(W)) rd();

    dig_capture #(
        .WIDTH      (W),
        .FIFO_DEPTH (DEPTH),
        .DIS_CYCLES (DIS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .count     (count),
        .cmp       (cmp),
        .clear     (clear),
        .discharge (discharge),
        .rd        (rd),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    cap_result_t  q[$];
    logic [W-1:0] start_m;

    // Free-running counter, changes just after each rising edge.
    initial begin
        count = '0;
        forever begin
            @(posedge clk);
            #1;
            count = count + 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkd(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_count(input logic [W-1:0] v);
        int n;
        n = 0;
        while (count !== v && n < 300) begin
            tick();
            n++;
        end
        n_checks++;
        assert (n < 300) else begin
            n_fail++;
            $error("FAIL wait_count: observed %0d cycles expected < 300", n);
        end
    endtask

    task automatic sb_pop_check(input string tag);
        check1({tag, "_valid"}, rd.out_valid, 1'b1);
        n_checks++;
        assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end
        if (q.size() != 0) checkd(tag, rd.out_data, q.pop_front());
        rd.out_ready = 1'b1;
        tick();
        rd.out_ready = 1'b0;
    endtask

    // Pulse cmp now (count at edge N = current count); capture lands at N+2.
    task automatic fire_cmp(input bit pop_at_push, input bit kill_enable);
        logic [W-1:0] c;
        cap_result_t  r;
        bit           drop;
        bit           was_empty;
        was_empty  = (q.size() == 0);
        cmp        = 1'b1;
        c          = count;
        r.timeout  = 1'b0;
        r.elapsed  = c + 8'd2 - start_m;
        tick();
        cmp = 1'b0;
        if (was_empty) check1("valid_lat_n", rd.out_valid, 1'b0);
        tick();
        if (was_empty) check1("valid_lat_n1", rd.out_valid, 1'b0);
        check1("dis_wait", discharge, 1'b0);
        drop = (q.size() >= DEPTH) && !pop_at_push;
        if (pop_at_push) begin
            check1("full_valid", rd.out_valid, 1'b1);
            checkd("pop_at_push", rd.out_data, q.pop_front());
            rd.out_ready = 1'b1;
        end
        if (!drop) q.push_back(r);
        tick();
        rd.out_ready = 1'b0;
        check1("valid_after_push", rd.out_valid, 1'b1);
        for (int i = 0; i < DIS; i++) begin
            check1("dis_pulse", discharge, 1'b1);
            if (kill_enable && i == 1) enable = 1'b0;
            tick();
        end
        check1("dis_exit", discharge, !enable);
        if (enable) start_m = c + 8'd6;
    endtask

    initial begin
        cap_result_t  tr;
        logic [W-1:0] t;

        reset_n      = 1'b0;
        enable       = 1'b0;
        cmp          = 1'b0;
        clear        = 1'b0;
        rd.out_ready = 1'b0;
        start_m      = '0;
        tick();
        tick();
        check1("rst_discharge", discharge, 1'b1);
        check1("rst_valid", rd.out_valid, 1'b0);
        checkd("rst_data", rd.out_data, 9'h000);
        check1("rst_overrun", overrun, 1'b0);
        reset_n = 1'b1;
        tick();
        check1("idle_discharge", discharge, 1'b1);

        // Basic capture: start 10, cmp sampled at 40 -> {0,32}.
        wait_count(8'd10);
        enable  = 1'b1;
        start_m = 8'd10;
        tick();
        check1("wait_discharge", discharge, 1'b0);
        wait_count(8'd40);
        fire_cmp(1'b0, 1'b0);
        sb_pop_check("basic");
        check1("basic_drained", rd.out_valid, 1'b0);

        // Enable drop in WAIT_CMP coinciding with a comparator rise: no push.
        cmp = 1'b1;
        tick();
        cmp = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        check1("endrop_discharge", discharge, 1'b1);
        check1("endrop_nopush", rd.out_valid, 1'b0);
        tick();
        check1("endrop_nopush2", rd.out_valid, 1'b0);

        // Wrap-around: start 250, captured at 5 -> {0,11}.
        wait_count(8'd250);
        enable  = 1'b1;
        start_m = 8'd250;
        tick();
        check1("wrap_wait", discharge, 1'b0);
        wait_count(8'd3);
        fire_cmp(1'b0, 1'b0);
        sb_pop_check("wrap");

        // Timeout: cmp held low -> {1,255} exactly 255 cycles after entry.
        t = start_m + 8'd255;
        wait_count(t);
        check1("timeout_not_early", rd.out_valid, 1'b0);
        tr.timeout = 1'b1;
        tr.elapsed = 8'hFF;
        q.push_back(tr);
        tick();
        check1("timeout_valid", rd.out_valid, 1'b1);
        check1("timeout_discharge", discharge, 1'b1);
        sb_pop_check("timeout");
        repeat (3) tick();
        start_m = t + 8'd4;
        check1("timeout_exit", discharge, 1'b0);

        // Trip on the timeout edge: trip wins -> {0,255}.
        wait_count(start_m + 8'd253);
        fire_cmp(1'b0, 1'b0);
        sb_pop_check("tie");
        check1("tie_single", rd.out_valid, 1'b0);

        // Backpressure and overflow: five captures into four slots.
        for (int i = 0; i < 5; i++) begin
            fire_cmp(1'b0, 1'b0);
            checkd("head_stable", rd.out_data, q[0]);
            check1("overrun_flag", overrun, (i == 4) ? 1'b1 : 1'b0);
        end
        check1("full_held", rd.out_valid, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check1("overrun_cleared", overrun, 1'b0);

        // Full FIFO with a pop on the push edge: nothing dropped.
        fire_cmp(1'b1, 1'b0);
        check1("pop_push_no_drop", overrun, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            sb_pop_check("drain");
        end
        check1("drain_empty", rd.out_valid, 1'b0);

        // Enable drop mid-discharge: full pulse, then IDLE.
        fire_cmp(1'b0, 1'b1);
        sb_pop_check("kill");
        check1("kill_idle", discharge, 1'b1);

        // Reset during DISCHARGE with two entries buffered.
        enable  = 1'b1;
        start_m = count;
        tick();
        check1("rearm_wait", discharge, 1'b0);
        fire_cmp(1'b0, 1'b0);
        cmp = 1'b1;
        tick();
        cmp = 1'b0;
        tick();
        tick();
        check1("pre_rst_valid", rd.out_valid, 1'b1);
        check1("pre_rst_dis", discharge, 1'b1);
        enable = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check1("midrst_discharge", discharge, 1'b1);
        check1("midrst_valid", rd.out_valid, 1'b0);
        checkd("midrst_data", rd.out_data, 9'h000);
        check1("midrst_overrun", overrun, 1'b0);
        q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check1("post_rst_valid", rd.out_valid, 1'b0);

        // Fresh measurement after reset behaves like the basic case.
        wait_count(8'd10);
        enable  = 1'b1;
        start_m = 8'd10;
        tick();
        wait_count(8'd40);
        fire_cmp(1'b0, 1'b0);
        sb_pop_check("post_rst_basic");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
